// File: rtl/mul_acc_int16_if.sv
// rtl/mul_acc_int16_if.sv - product-in / sum-out handshake bundle for mul_acc_int16
interface mul_acc_int16_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CW        = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_prod;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]        out_count;
  logic                 out_forced;
  logic                 out_sat;
  logic                 busy;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_forced, out_sat, busy
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_forced, out_sat, busy
  );
endinterface

// File: rtl/mul_acc_int16.sv
// rtl/mul_acc_int16.sv - accumulates a transaction of multiplier products into one result
// Optional MUL_ACC_SAT_EN: clamp each add to the accumulator range and report out_sat.
module mul_acc_int16 #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int MAX_TERMS = 16,
  parameter int SIGNED    = 1
) (
  input  logic           clk,
  input  logic           rst,
  mul_acc_int16_if.slave bus
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc, acc_nxt, ext, add_res;
  logic [CW-1:0]        count, count_nxt;
  logic                 forced, forced_nxt;
  logic [WIDTH-1:0]     prod;
  logic                 in_ready, accept, at_limit;

  assign prod     = bus.in_prod;
  assign in_ready = (state != DONE);
  assign accept   = bus.in_valid & in_ready;
  assign at_limit = (count == CW'(MAX_TERMS - 1));

  always_comb begin
    if (SIGNED != 0) ext = ACC_WIDTH'($signed(prod));
    else             ext = ACC_WIDTH'(prod);
  end

`ifdef MUL_ACC_SAT_EN
  logic [ACC_WIDTH:0] true_sum;
  logic               add_clamp;
  logic               sat;

  // One extra bit of headroom tells overflow apart from a legitimate MSB.
  always_comb begin
    add_clamp = 1'b0;
    if (SIGNED != 0) begin
      true_sum = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
      add_res  = true_sum[ACC_WIDTH-1:0];
      if (true_sum[ACC_WIDTH] != true_sum[ACC_WIDTH-1]) begin
        add_clamp = 1'b1;
        add_res   = {true_sum[ACC_WIDTH], {(ACC_WIDTH-1){~true_sum[ACC_WIDTH]}}};
      end
    end else begin
      true_sum = {1'b0, acc} + {1'b0, ext};
      add_res  = true_sum[ACC_WIDTH-1:0];
      if (true_sum[ACC_WIDTH]) begin
        add_clamp = 1'b1;
        add_res   = {ACC_WIDTH{1'b1}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         sat <= 1'b0;
    else if (accept) sat <= (state == IDLE) ? 1'b0 : (sat | add_clamp);
  end

  assign bus.out_sat = sat;
`else
  assign add_res     = acc + ext;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      count  <= '0;
      forced <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      count  <= count_nxt;
      forced <= forced_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    count_nxt  = count;
    forced_nxt = forced;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt    = ext;
          count_nxt  = CW'(1);
          forced_nxt = (MAX_TERMS == 1) && !bus.in_last;
          state_nxt  = (bus.in_last || MAX_TERMS == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_nxt    = add_res;
          count_nxt  = count + CW'(1);
          forced_nxt = at_limit && !bus.in_last;
          if (bus.in_last || at_limit) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum/count registers stay frozen in DONE, so they double as the result registers.
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_sum    = acc;
  assign bus.out_count  = count;
  assign bus.out_forced = forced;
endmodule
